// File: rtl/ad_scheduler_if.sv
// ad_scheduler_if: request and served-ad valid/ready handshakes between front-end and scheduler
interface ad_scheduler_if;
  logic       req_valid;
  logic       req_ready;
  logic       A;
  logic       F;
  logic [1:0] T;
  logic       ad_valid;
  logic       ad_ready;
  logic [1:0] ad;
  logic       ad_none;
  modport master(output req_valid, A, F, T, ad_ready, input req_ready, ad_valid, ad, ad_none);
  modport slave(input req_valid, A, F, T, ad_ready, output req_ready, ad_valid, ad, ad_none);
endinterface

// File: rtl/ad_scheduler.sv
// ad_scheduler: budgeted movie-ad selection FSM; AD_SERVE_COUNT_EN adds a saturating served_count output
module ad_scheduler #(
  parameter int BUDGET_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*BUDGET_W-1:0] budget_in,
  output logic [4*BUDGET_W-1:0] budget_left,
  ad_scheduler_if.slave         bus
`ifdef AD_SERVE_COUNT_EN
  ,
  output logic [15:0]           served_count
`endif
);
  typedef enum logic [1:0] {IDLE, SELECT, SERVE} state_t;
  state_t state, next_state;
  logic cap_a, cap_f, found, none_r, accept;
  logic [1:0] cap_t, pref, pick, ad_r;
  logic [3:0][BUDGET_W-1:0] budget;
  assign accept = state == SERVE && bus.ad_ready;
  assign pref = ((cap_t == 2'd0 || cap_t == 2'd3) && !cap_f && !cap_a) ? 2'd0 :
                (cap_t == 2'd1 || (cap_f && cap_t != 2'd2))           ? 2'd1 :
                (cap_a || cap_t == 2'd0 || cap_t == 2'd2)              ? 2'd2 : 2'd3;
  // walk the rotation backwards so the nearest funded ad after P wins
  always_comb begin
    pick  = pref;
    found = 1'b0;
    for (int k = 3; k >= 0; k--)
      if (budget[pref + 2'(k)] != '0) begin
        pick  = pref + 2'(k);
        found = 1'b1;
      end
  end
  always_comb
    next_state = state == IDLE   ? (bus.req_valid ? SELECT : IDLE) :
                 state == SELECT ? SERVE :
                 (bus.ad_ready ? IDLE : SERVE);
  always_ff @(posedge clk)
    state <= reset ? IDLE : next_state;
  always_ff @(posedge clk)
    if (reset) {cap_a, cap_f, cap_t} <= '0;
    else if (state == IDLE && bus.req_valid) {cap_a, cap_f, cap_t} <= {bus.A, bus.F, bus.T};
  always_ff @(posedge clk)
    if (reset) {ad_r, none_r} <= '0;
    else if (state == SELECT) {ad_r, none_r} <= {pick, !found};
  // a load may zero the registered ad while in SERVE, so the decrement still guards against underflow
  always_ff @(posedge clk)
    if (reset) budget <= '0;
    else if (load) budget <= budget_in;
    else if (accept && !none_r && budget[ad_r] != '0) budget[ad_r] <= budget[ad_r] - BUDGET_W'(1);
`ifdef AD_SERVE_COUNT_EN
  always_ff @(posedge clk)
    if (reset) served_count <= '0;
    else if (accept && !none_r && served_count != 16'hFFFF) served_count <= served_count + 16'd1;
`endif
  assign budget_left  = budget;
  assign bus.req_ready = state == IDLE;
  assign bus.ad_valid  = state == SERVE;
  assign bus.ad        = ad_r;
  assign bus.ad_none   = none_r;
endmodule

// File: tb/tb_ad_scheduler.sv
// tb_ad_scheduler: scoreboarded random and directed stimulus against a rule-level ad selection model
module tb_ad_scheduler;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic [4*W-1:0] budget_in = '0;
  logic [4*W-1:0] budget_left;
  ad_scheduler_if bus();
`ifdef AD_SERVE_COUNT_EN
  logic [15:0] served_count;
  int exp_count = 0;
`endif
  ad_scheduler #(.BUDGET_W(W)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .budget_in(budget_in),
    .budget_left(budget_left),
    .bus(bus.slave)
`ifdef AD_SERVE_COUNT_EN
    ,
    .served_count(served_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [1:0] ad; logic none;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int vectors = 0;
  int miscompares = 0;
  int model[4];
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int preferred(bit a, bit f, bit [1:0] t);
    if ((t == 0 || t == 3) && !f && !a) return 0;
    if (t == 1 || (f && t != 2)) return 1;
    if (a || t == 0 || t == 2) return 2;
    return 3;
  endfunction
  function automatic logic [4*W-1:0] pack();
    logic [4*W-1:0] v;
    for (int i = 0; i < 4; i++) v[i*W +: W] = W'(model[i]);
    return v;
  endfunction
  always @(negedge clk)
    if (!reset && bus.ad_valid && bus.ad_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_serve: got ad %0d with empty scoreboard", bus.ad);
      end else begin
        mon_e = exp_q.pop_front();
        check("serve_ad", 64'(bus.ad), 64'(mon_e.ad));
        check("serve_none", 64'(bus.ad_none), 64'(mon_e.none));
      end
    end
  task automatic do_load(int v0, int v1, int v2, int v3);
    @(posedge clk); #1;
    load = 1'b1;
    model = '{v0, v1, v2, v3};
    budget_in = pack();
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    check("load_budget", 64'(budget_left), 64'(pack()));
  endtask
  task automatic do_req(bit a, bit f, bit [1:0] t, int stall, bit load_sel, bit load_acc, int lv, bit rst_serve);
    int p, sel;
    bit none;
    logic [4*W-1:0] pre;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.A = a;
    bus.F = f;
    bus.T = t;
    @(negedge clk);
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    p = preferred(a, f, t);
    sel = p;
    none = 1'b1;
    for (int k = 0; k < 4 && none; k++)
      if (model[(p + k) % 4] > 0) begin
        sel = (p + k) % 4;
        none = 1'b0;
      end
    exp_q.push_back('{2'(sel), none});
    @(posedge clk); #1;
    bus.req_valid = 1'($urandom_range(0, 1));
    bus.A = 1'($urandom);
    bus.F = 1'($urandom);
    bus.T = 2'($urandom);
    if (load_sel) begin
      load = 1'b1;
      budget_in = {4{W'(lv)}};
    end
    @(negedge clk);
    check("select_valid", 64'(bus.ad_valid), 64'd0);
    check("select_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (load_sel) begin
      load = 1'b0;
      model = '{lv, lv, lv, lv};
    end
    pre = pack();
    if (rst_serve) begin
      @(negedge clk);
      check("serve_valid", 64'(bus.ad_valid), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      void'(exp_q.pop_back());
      model = '{0, 0, 0, 0};
`ifdef AD_SERVE_COUNT_EN
      exp_count = 0;
`endif
      @(negedge clk);
      check("rst_valid", 64'(bus.ad_valid), 64'd0);
      check("rst_ready", 64'(bus.req_ready), 64'd1);
      check("rst_budget", 64'(budget_left), 64'd0);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      bus.ad_ready = 1'b0;
      @(negedge clk);
      check("stall_valid", 64'(bus.ad_valid), 64'd1);
      check("stall_ready", 64'(bus.req_ready), 64'd0);
      check("stall_ad", 64'(bus.ad), 64'(sel));
      check("stall_budget", 64'(budget_left), 64'(pre));
      @(posedge clk); #1;
    end
    bus.ad_ready = 1'b1;
    if (load_acc) begin
      load = 1'b1;
      budget_in = {4{W'(lv)}};
    end
    @(negedge clk);
    check("serve_valid", 64'(bus.ad_valid), 64'd1);
    @(posedge clk); #1;
    bus.ad_ready = 1'b0;
    if (load_acc) begin
      load = 1'b0;
      model = '{lv, lv, lv, lv};
    end else if (!none && model[sel] > 0) model[sel]--;
`ifdef AD_SERVE_COUNT_EN
    if (!none && exp_count < 16'hFFFF) exp_count++;
`endif
    @(negedge clk);
    check("idle_valid", 64'(bus.ad_valid), 64'd0);
    check("idle_ready", 64'(bus.req_ready), 64'd1);
    check("budget", 64'(budget_left), 64'(pack()));
`ifdef AD_SERVE_COUNT_EN
    check("served_count", 64'(served_count), 64'(exp_count));
`endif
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.A = 1'b0;
    bus.F = 1'b0;
    bus.T = 2'd0;
    bus.ad_ready = 1'b0;
    model = '{0, 0, 0, 0};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ready", 64'(bus.req_ready), 64'd1);
    check("reset_valid", 64'(bus.ad_valid), 64'd0);
    check("reset_ad", 64'(bus.ad), 64'd0);
    check("reset_none", 64'(bus.ad_none), 64'd0);
    check("reset_budget", 64'(budget_left), 64'd0);
    do_load(3, 3, 3, 3);
    do_req(0, 0, 2'd0, 0, 0, 0, 0, 0);
    do_load(0, 0, 5, 1);
    do_req(0, 0, 2'd3, 0, 0, 0, 0, 0);
    do_load(0, 0, 0, 0);
    do_req(0, 1, 2'd0, 0, 0, 0, 0, 0);
    do_load(2, 2, 2, 2);
    do_req(1, 0, 2'd2, 5, 0, 0, 0, 0);
    do_req(0, 0, 2'd1, 0, 0, 1, 7, 0);
    do_req(0, 1, 2'd3, 1, 1, 0, 4, 0);
    do_req(1, 1, 2'd0, 0, 0, 0, 0, 1);
    do_req(0, 0, 2'd1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0)
        do_load($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      do_req(1'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3), 0);
    end
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
